// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: sync, debounce, press/release pulses,
// one-shot long-press and optional auto-repeat per channel.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS       = 2,
    parameter int unsigned DEBOUNCE_CYC   = 500000,
    parameter int unsigned LONG_CYC       = 50000000,
    parameter int unsigned REPEAT_CYC     = 10000000,
    parameter int unsigned KEY_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                repeat_en,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned DW       = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HW       = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } hold_state_e;

    logic [NUM_KEYS-1:0] key_norm;

    assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        logic          sync1_q, sync2_q;
        logic          level_q, level_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        hold_state_e   state_q, state_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          acc_press, acc_release;

        always_comb begin
            level_d     = level_q;
            dcnt_d      = dcnt_q;
            state_d     = state_q;
            hcnt_d      = hcnt_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            acc_press   = 1'b0;
            acc_release = 1'b0;

            if (sync2_q == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                level_d     = sync2_q;
                dcnt_d      = '0;
                acc_press   = sync2_q;
                acc_release = ~sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (acc_press) begin
                        state_d = StHold;
                        hcnt_d  = '0;
                    end
                end
                StHold: begin
                    if (hcnt_q == HW'(LONG_CYC - 1)) begin
                        long_d  = 1'b1;
                        state_d = StRepeat;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                StRepeat: begin
                    // Period keeps running with repeat_en low so toggling never shifts ticks.
                    if (hcnt_q == HW'(REPEAT_CYC - 1)) begin
                        hcnt_d  = '0;
                        press_d = repeat_en;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    hcnt_d  = '0;
                end
            endcase

            // Accepted release overrides anything the hold FSM wanted this cycle.
            if (acc_release) begin
                state_d = StIdle;
                hcnt_d  = '0;
                press_d = 1'b0;
                long_d  = 1'b0;
            end
            if (acc_press) begin
                press_d = 1'b1;
            end
            release_d = acc_release;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                dcnt_q    <= '0;
                state_q   <= StIdle;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync1_q   <= key_norm[i];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                dcnt_q    <= dcnt_d;
                state_q   <= state_d;
                hcnt_q    <= hcnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: table-driven segments plus per-cycle hold sequences,
// expectations queued at drive time and checked 1 ns after the following clock edge.
module tb_key_debounce_multi;

    logic       clk;
    logic       rst;
    logic       repeat_en;
    logic [1:0] key_in;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_long;

    key_debounce_multi #(
        .NUM_KEYS      (2),
        .DEBOUNCE_CYC  (8),
        .LONG_CYC      (40),
        .REPEAT_CYC    (10),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .repeat_en  (repeat_en),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] lng;
    } exp_t;

    typedef struct {
        logic        r;
        logic        ren;
        logic [1:0]  k;
        int unsigned n;
        logic [1:0]  lvl;
        logic [1:0]  prs;
        logic [1:0]  rel;
        logic [1:0]  lng;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rec     = 0;

    // Scoreboard: one expectation per clock edge, sampled just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            rec++;
            n_tests++;
            if ({key_level, key_press, key_release, key_long} !== e) begin
                n_fail++;
                $display("FAIL rec%0d: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
                         rec, key_level, key_press, key_release, key_long,
                         e.lvl, e.prs, e.rel, e.lng);
            end
        end
    end

    task automatic step(input logic r, input logic ren, input logic [1:0] k,
                        input logic [1:0] lvl, input logic [1:0] prs,
                        input logic [1:0] rel, input logic [1:0] lng);
        exp_t e;
        rst       = r;
        repeat_en = ren;
        key_in    = k;
        e.lvl = lvl;
        e.prs = prs;
        e.rel = rel;
        e.lng = lng;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    // Hold key1 (repeat_en schedule selects the repeat variant); t counts edges from acceptance.
    task automatic long_hold(input bit ren_window);
        for (int i = 1; i <= 120; i++) begin
            int         t;
            logic       ren;
            logic       prs;
            t   = i - 10;
            ren = ren_window ? (t >= 55 && t < 85) : 1'b1;
            if (ren_window) prs = (t == 0) || (t >= 60 && t <= 80 && t % 10 == 0);
            else            prs = (t == 0) || (t >= 50 && t < 110 && t % 10 == 0);
            step(1'b0, ren, (t <= 100) ? 2'b01 : 2'b11,
                 {(t >= 0 && t < 110), 1'b0}, {prs, 1'b0},
                 {(t == 110), 1'b0}, {(t == 40), 1'b0});
        end
        idle(3);
    endtask

    vec_t tbl[$];

    initial begin
        rst       = 1'b1;
        repeat_en = 1'b0;
        key_in    = 2'b11;

        // Reset with both keys pressed, then release both.
        tbl.push_back('{1'b1, 1'b0, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b00, 9, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 9, 2'b11, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 5, 2'b00, 2'b00, 2'b00, 2'b00});
        // Bounce on key0: low 5, high 2, low held; accepted 8 edges after last s change.
        tbl.push_back('{1'b0, 1'b0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b10, 9, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b10, 5, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 9, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00});
        // Seven-cycle glitch is one short of acceptance.
        tbl.push_back('{1'b0, 1'b0, 2'b10, 7, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{1'b0, 1'b0, 2'b11, 12, 2'b00, 2'b00, 2'b00, 2'b00});

        @(negedge clk);
        foreach (tbl[v]) begin
            for (int j = 0; j < int'(tbl[v].n); j++) begin
                step(tbl[v].r, tbl[v].ren, tbl[v].k, tbl[v].lvl, tbl[v].prs,
                     tbl[v].rel, tbl[v].lng);
            end
        end

        long_hold(1'b0);
        long_hold(1'b1);

        // key0 reaches REPEAT, key1 mid-debounce, then a one-cycle reset.
        for (int i = 1; i <= 60; i++) begin
            int t;
            t = i - 10;
            if (t == 50) begin
                step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
            end else begin
                step(1'b0, 1'b1, (t >= 46) ? 2'b00 : 2'b10,
                     {1'b0, (t >= 0)}, {1'b0, (t == 0)}, 2'b00, {1'b0, (t == 40)});
            end
        end
        for (int u = 1; u <= 75; u++) begin
            logic p;
            p = (u == 10) || (u >= 60 && u < 72 && u % 10 == 0);
            step(1'b0, 1'b1, (u <= 62) ? 2'b00 : 2'b11,
                 {2{(u >= 10 && u < 72)}}, {2{p}}, {2{(u == 72)}}, {2{(u == 50)}});
        end
        idle(3);

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised N-channel push-button conditioner for the game-box front panel, replacing the fixed two-key filter. Each channel synchronises a raw (bouncy, asynchronous) key and debounces both press and release. It produces a clean level, one-cycle press and release pulses, a one-shot long-press pulse, and optional auto-repeat. Outputs feed the game FSM and menu logic directly.

Parameters:
NUM_KEYS, 2, number of independent key channels (>=1)
DEBOUNCE_CYC, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); >=2
LONG_CYC, 50000000, cycles held (after accepted press) before long-press fires (1 s); > DEBOUNCE_CYC
REPEAT_CYC, 10000000, auto-repeat period after long-press (200 ms); >=2
KEY_ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: reads 1 when pressed
Counter widths derived internally with $clog2 of the largest count; no width parameters.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
repeat_en  in  1  global auto-repeat enable, sampled every cycle
key_in  in  NUM_KEYS  raw key pins, asynchronous
key_level  out  NUM_KEYS  debounced pressed state, 1 = pressed
key_press  out  NUM_KEYS  1-cycle pulse: accepted press, or auto-repeat tick
key_release  out  NUM_KEYS  1-cycle pulse: accepted release
key_long  out  NUM_KEYS  1-cycle pulse: held for LONG_CYC

Behaviour:
- All channels identical and fully independent; no arbitration between simultaneous keys.
- Reset (rst=1 at clk edge): sync flops load "released", key_level=0, all pulses 0, all counters 0. Reset dominates any in-flight count; no pulse is emitted on reset entry or exit.
- Polarity: raw normalised to pressed=1 before synchronising per KEY_ACTIVE_LOW.
- Sync: 2-flop synchroniser per channel; s = second flop output.
- Debounce counter dcnt: if s == key_level, dcnt<=0. Else if dcnt == DEBOUNCE_CYC-1, key_level<=s and dcnt<=0. Else dcnt<=dcnt+1.
- Latency: s must differ from key_level for DEBOUNCE_CYC consecutive cycles. key_level flips at the DEBOUNCE_CYC-th edge after s changes, i.e. DEBOUNCE_CYC+2 edges after a clean raw edge. Any return of s to key_level before then restarts the count (bounce rejected).
- key_press/key_release are registered and asserted in the same cycle key_level becomes 1/0. They are high exactly one cycle.
- Hold FSM per channel: IDLE, HOLD, REPEAT; counter hcnt.
  - IDLE: on accepted press -> HOLD, hcnt<=0.
  - HOLD: hcnt increments each cycle. When hcnt == LONG_CYC-1: key_long=1 for one cycle, go REPEAT, hcnt<=0.
  - REPEAT: hcnt increments. When hcnt == REPEAT_CYC-1: hcnt<=0, and if repeat_en=1, key_press=1 for one cycle. With repeat_en=0, hcnt still wraps but no pulse.
  - Any state: accepted release -> IDLE, hcnt<=0. Release before LONG_CYC -> no key_long.
- key_long fires at most once per press. First auto-repeat pulse comes REPEAT_CYC cycles after key_long.
- repeat_en toggling mid-hold takes effect at the next REPEAT_CYC boundary; it never shortens or shifts the period.
- Release pulse and a repeat-tick can never coincide: release forces IDLE in the same cycle, and release wins.

Test Plan (DEBOUNCE_CYC=8, LONG_CYC=40, REPEAT_CYC=10, NUM_KEYS=2, active-low):
1. Reset: rst=1 for 3 cycles with key_in=2'b00 (both pressed) -> all outputs 0 during reset; key_level=2'b11 exactly 10 cycles after rst falls, with key_press=2'b11 for that one cycle.
2. Bounce: key_in[0] low 5 cycles, high 2, low held -> key_level[0] rises 8 cycles after the last s change; exactly one key_press[0]; key_release[0] never pulses.
3. Short glitch: key_in[0] low for 7 cycles then high -> no change on any output.
4. Long press, repeat_en=1: hold key_in[1] low 100 cycles after acceptance -> key_long[1] at hold cycle 40; key_press[1] at 50, 60, 70, 80, 90, 100 (relative to acceptance); on release, one key_release[1] 8+2 cycles after raw rise; no key_press with it.
5. Long press, repeat_en=0: same stimulus -> key_long[1] once; no repeat pulses. Assert repeat_en at hold cycle 55 -> next key_press[1] at 60.
6. Independence plus mid-operation reset: key0 in REPEAT, key1 in debounce; rst pulses 1 cycle -> all outputs 0 next cycle; with keys still held, re-acceptance after 10 cycles with fresh key_press; key_long 40 cycles later.
